// File: rtl/vga_timing_pmod.sv
// vga_timing_pmod: parametrised VGA timing generator with TinyVGA PMOD output stage.
// Produces pixel coordinates for the renderer, delays the blanking/sync controls
// by the renderer latency, and registers colour plus syncs onto the 8-bit PMOD bus.
//
// Handshake: there is no valid/ready pair on this block. tick_o is the single
// qualifier: x_o/y_o/line_o/frame_o describe the pixel of the current tick, rgb_i
// is sampled only on clocks where tick_o is high, and the renderer cannot stall it.
module vga_timing_pmod #(
    parameter int H_ACTIVE   = 640,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 48,
    parameter int V_ACTIVE   = 480,
    parameter int V_FP       = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 33,
    parameter int H_SYNC_POL = 0,
    parameter int V_SYNC_POL = 0,
    parameter int CLK_DIV    = 1,
    parameter int RGB_BITS   = 2,
    parameter int LATENCY    = 0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [3*RGB_BITS-1:0]   rgb_i,
    output logic [9:0]              x_o,
    output logic [9:0]              y_o,
    output logic                    tick_o,
    output logic                    frame_o,
    output logic                    line_o,
    output logic [7:0]              pmod_o
);

    localparam int H_TOTAL      = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL      = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int H_SYNC_START = H_ACTIVE + H_FP;
    localparam int H_SYNC_END   = H_SYNC_START + H_SYNC;
    localparam int V_SYNC_START = V_ACTIVE + V_FP;
    localparam int V_SYNC_END   = V_SYNC_START + V_SYNC;
    localparam int DIV_W        = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic       HS_ON     = (H_SYNC_POL != 0);
    localparam logic       VS_ON     = (V_SYNC_POL != 0);
    // Idle bus: both syncs at their inactive level, all colour bits dark.
    localparam logic [7:0] PMOD_IDLE = {~HS_ON, 3'b000, ~VS_ON, 3'b000};

    logic [DIV_W-1:0] div;
    logic             tick;
    logic [9:0]       h;
    logic [9:0]       v;
    logic             h_last;
    logic             v_last;

    logic act0, hs0, vs0;
    logic act_d, hs_d, vs_d;

    logic r_hi, r_lo, g_hi, g_lo, b_hi, b_lo;
    logic hs_bit, vs_bit;
    logic [7:0] pmod_next;
    logic [7:0] pmod_q;

    // Pixel clock divider: div==0 marks the tick clock (always true for CLK_DIV=1).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div <= '0;
        end else if (div == DIV_W'(CLK_DIV - 1)) begin
            div <= '0;
        end else begin
            div <= div + 1'b1;
        end
    end

    assign tick   = (div == '0);
    assign h_last = (h == 10'(H_TOTAL - 1));
    assign v_last = (v == 10'(V_TOTAL - 1));

    // Raster counters: h advances each tick, v advances when h wraps.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            h <= '0;
            v <= '0;
        end else if (tick) begin
            if (h_last) begin
                h <= '0;
                if (v_last) begin
                    v <= '0;
                end else begin
                    v <= v + 10'd1;
                end
            end else begin
                h <= h + 10'd1;
            end
        end
    end

    // Stage-0 controls for the pixel currently presented on x_o/y_o.
    always_comb begin
        act0 = (h < 10'(H_ACTIVE)) && (v < 10'(V_ACTIVE));
        hs0  = (h >= 10'(H_SYNC_START)) && (h < 10'(H_SYNC_END));
        vs0  = (v >= 10'(V_SYNC_START)) && (v < 10'(V_SYNC_END));
    end

    // Controls are delayed by the renderer latency so they meet the matching colour.
    generate
        if (LATENCY == 0) begin : g_no_delay
            assign act_d = act0;
            assign hs_d  = hs0;
            assign vs_d  = vs0;
        end else begin : g_delay
            logic [2:0] ctrl_sr [LATENCY];

            // Tick-advanced shift register of {act, hs, vs}; cleared to blank/inactive.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    for (int i = 0; i < LATENCY; i++) begin
                        ctrl_sr[i] <= 3'b000;
                    end
                end else if (tick) begin
                    ctrl_sr[0] <= {act0, hs0, vs0};
                    for (int i = 1; i < LATENCY; i++) begin
                        ctrl_sr[i] <= ctrl_sr[i-1];
                    end
                end
            end

            assign {act_d, hs_d, vs_d} = ctrl_sr[LATENCY-1];
        end
    endgenerate

    // Channel bit selection: a 1-bit channel drives both TinyVGA weights.
    generate
        if (RGB_BITS == 2) begin : g_rgb2
            assign {r_hi, r_lo} = rgb_i[5:4];
            assign {g_hi, g_lo} = rgb_i[3:2];
            assign {b_hi, b_lo} = rgb_i[1:0];
        end else begin : g_rgb1
            assign r_hi = rgb_i[2];
            assign r_lo = rgb_i[2];
            assign g_hi = rgb_i[1];
            assign g_lo = rgb_i[1];
            assign b_hi = rgb_i[0];
            assign b_lo = rgb_i[0];
        end
    endgenerate

    // Next bus value: colour gated by act_d (masks any X during blanking), syncs by polarity.
    always_comb begin
        hs_bit    = hs_d ? HS_ON : ~HS_ON;
        vs_bit    = vs_d ? VS_ON : ~VS_ON;
        pmod_next = {hs_bit,
                     b_lo & act_d, g_lo & act_d, r_lo & act_d,
                     vs_bit,
                     b_hi & act_d, g_hi & act_d, r_hi & act_d};
    end

    // Output register: updates only on ticks, so the bus holds for CLK_DIV clocks.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pmod_q <= PMOD_IDLE;
        end else if (tick) begin
            pmod_q <= pmod_next;
        end
    end

    assign x_o     = h;
    assign y_o     = v;
    assign tick_o  = tick;
    assign line_o  = tick & (h == 10'd0);
    assign frame_o = tick & (h == 10'd0) & (v == 10'd0);
    assign pmod_o  = pmod_q;

endmodule
